// File: rtl/cpu_pkg.sv
// Shared widths, reset vector and fetch-entry layout for the 16-bit stack CPU front end.
package cpu_pkg;

  localparam int WORD_W     = 16;
  localparam int ADDR_W     = 16;
  localparam int FIFO_DEPTH = 2;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  // Prefetch FIFO entry: fetch address in the upper half, instruction word in the lower half.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {addr, instr} entries; flush wins over push/pop.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: drives the 1-cycle-latency program memory, buffers returned words and
// hands them to the core; a redirect flushes buffered and in-flight fetches.
module instr_fetch #(
  parameter int DATA_W = cpu_pkg::WORD_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DEPTH  = cpu_pkg::FIFO_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic              i_clock,
  input  logic              i_reset,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instr_addr,
  output logic              o_valid,
  input  logic              i_ready,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_addr,
  output logic [ADDR_W-1:0] o_ip
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int OCC_W   = CNT_W + 1;

  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  inflight_addr;
  logic               inflight;
  logic               pop;
  logic               push;
  logic               empty;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] head;
  logic [OCC_W-1:0]   occupancy;

  // Handshake: the head transfers on a cycle where o_valid && i_ready; o_valid never
  // depends on i_ready, and is forced low during reset and redirect cycles.
  assign o_valid = !i_reset && !empty && !i_redirect;
  assign pop     = o_valid && i_ready;
  assign push    = inflight && !i_redirect;

  // Credit check counts the slot freed by this cycle's pop, so a full-rate stream
  // keeps one word buffered and one in flight.
  assign occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
  assign o_mem_req = !i_reset && !i_redirect && (occupancy < OCC_W'(DEPTH));

  assign o_mem_addr   = fetch_pc;
  assign o_ip         = fetch_pc;
  assign o_instr      = head[DATA_W-1:0];
  assign o_instr_addr = head[ENTRY_W-1:DATA_W];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      fetch_pc      <= RESET_PC;
      inflight      <= 1'b0;
      inflight_addr <= RESET_PC;
    end else begin
      inflight <= o_mem_req;
      if (o_mem_req) begin
        inflight_addr <= fetch_pc;
      end
      if (i_redirect) begin
        fetch_pc <= i_redirect_addr;
      end else if (o_mem_req) begin
        fetch_pc <= fetch_pc + 1'b1;
      end
    end
  end

  fetch_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clock),
    .rst   (i_reset),
    .flush (i_redirect),
    .push  (push),
    .pop   (pop),
    .wdata ({inflight_addr, i_mem_data}),
    .head  (head),
    .count (count),
    .empty (empty)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: startup latency, backpressure, redirect, address wrap
// and mid-stream reset, against a program memory holding A000+addr.
module tb_instr_fetch;

  logic        clk;
  logic        i_reset;
  logic        o_mem_req;
  logic [15:0] o_mem_addr;
  logic [15:0] i_mem_data;
  logic [15:0] o_instr;
  logic [15:0] o_instr_addr;
  logic        o_valid;
  logic        i_ready;
  logic        i_redirect;
  logic [15:0] i_redirect_addr;
  logic [15:0] o_ip;

  int checks = 0;
  int errors = 0;

  instr_fetch dut (
    .i_clock         (clk),
    .i_reset         (i_reset),
    .o_mem_req       (o_mem_req),
    .o_mem_addr      (o_mem_addr),
    .i_mem_data      (i_mem_data),
    .o_instr         (o_instr),
    .o_instr_addr    (o_instr_addr),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .i_redirect      (i_redirect),
    .i_redirect_addr (i_redirect_addr),
    .o_ip            (o_ip)
  );

  // Clock and synchronous program memory (mem[a] = A000 + a, one-cycle latency).
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial i_mem_data = 16'h0000;
  always @(posedge clk) begin
    if (o_mem_req) i_mem_data <= 16'hA000 + o_mem_addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] addr, input logic [15:0] instr);
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_addr"}, 32'(o_instr_addr), 32'(addr));
    chk({tag, "_instr"}, 32'(o_instr), 32'(instr));
  endtask

  initial begin
    i_reset = 1'b1;
    i_ready = 1'b1;
    i_redirect = 1'b0;
    i_redirect_addr = 16'h0000;

    // Two reset cycles.
    mid();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_req", 32'(o_mem_req), 32'd0);
    tick(); mid();
    chk("rst_ip", 32'(o_ip), 32'h0000);
    chk("rst_valid2", 32'(o_valid), 32'd0);
    chk("rst_req2", 32'(o_mem_req), 32'd0);

    // t0: release reset, first request immediately.
    tick(); i_reset = 1'b0; mid();
    chk("t0_req", 32'(o_mem_req), 32'd1);
    chk("t0_addr", 32'(o_mem_addr), 32'h0000);
    chk("t0_valid", 32'(o_valid), 32'd0);
    tick(); mid();
    chk("t1_req", 32'(o_mem_req), 32'd1);
    chk("t1_addr", 32'(o_mem_addr), 32'h0001);
    chk("t1_valid", 32'(o_valid), 32'd0);
    tick(); mid();
    chk_out("t2", 16'h0000, 16'hA000);
    chk("t2_addr_req", 32'(o_mem_addr), 32'h0002);
    tick(); mid();
    chk_out("t3", 16'h0001, 16'hA001);
    tick(); mid();
    chk_out("t4", 16'h0002, 16'hA002);

    // Backpressure for 6 cycles: head held, requests stop.
    tick(); i_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      mid();
      chk_out("stall", 16'h0003, 16'hA003);
      chk("stall_req", 32'(o_mem_req), 32'd0);
      tick();
    end
    i_ready = 1'b1; mid();
    chk_out("rel0", 16'h0003, 16'hA003);
    chk("rel0_req", 32'(o_mem_req), 32'd1);
    chk("rel0_addr", 32'(o_mem_addr), 32'h0005);
    tick(); mid();
    chk_out("rel1", 16'h0004, 16'hA004);
    tick(); mid();
    chk_out("rel2", 16'h0005, 16'hA005);

    // Redirect to 1234 with ready high and the FIFO non-empty.
    tick(); i_redirect = 1'b1; i_redirect_addr = 16'h1234; mid();
    chk("rd_t_valid", 32'(o_valid), 32'd0);
    chk("rd_t_req", 32'(o_mem_req), 32'd0);
    tick(); i_redirect = 1'b0; mid();
    chk("rd_t1_valid", 32'(o_valid), 32'd0);
    chk("rd_t1_req", 32'(o_mem_req), 32'd1);
    chk("rd_t1_addr", 32'(o_mem_addr), 32'h1234);
    chk("rd_t1_ip", 32'(o_ip), 32'h1234);
    tick(); mid();
    chk("rd_t2_valid", 32'(o_valid), 32'd0);
    chk("rd_t2_addr", 32'(o_mem_addr), 32'h1235);
    tick(); mid();
    chk_out("rd_t3", 16'h1234, 16'hB234);
    tick(); mid();
    chk_out("rd_t4", 16'h1235, 16'hB235);

    // Redirect to FFFE: address wrap.
    tick(); i_redirect = 1'b1; i_redirect_addr = 16'hFFFE; mid();
    chk("wr_t_valid", 32'(o_valid), 32'd0);
    tick(); i_redirect = 1'b0; mid();
    chk("wr_t1_valid", 32'(o_valid), 32'd0);
    chk("wr_t1_addr", 32'(o_mem_addr), 32'hFFFE);
    tick(); mid();
    chk("wr_t2_valid", 32'(o_valid), 32'd0);
    chk("wr_t2_addr", 32'(o_mem_addr), 32'hFFFF);
    tick(); mid();
    chk_out("wr_t3", 16'hFFFE, 16'h9FFE);
    chk("wr_t3_addr", 32'(o_mem_addr), 32'h0000);
    tick(); mid();
    chk_out("wr_t4", 16'hFFFF, 16'h9FFF);
    chk("wr_t4_ip", 32'(o_ip), 32'h0001);
    tick(); mid();
    chk_out("wr_t5", 16'h0000, 16'hA000);

    // One-cycle reset mid-stream with a request in flight.
    tick(); i_reset = 1'b1; mid();
    chk("mr_valid", 32'(o_valid), 32'd0);
    chk("mr_req", 32'(o_mem_req), 32'd0);
    tick(); i_reset = 1'b0; mid();
    chk("mr_t0_valid", 32'(o_valid), 32'd0);
    chk("mr_t0_req", 32'(o_mem_req), 32'd1);
    chk("mr_t0_addr", 32'(o_mem_addr), 32'h0000);
    tick(); mid();
    chk("mr_t1_valid", 32'(o_valid), 32'd0);
    tick(); mid();
    chk_out("mr_t2", 16'h0000, 16'hA000);
    tick(); mid();
    chk_out("mr_t3", 16'h0001, 16'hA001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
